// File: rtl/mblock_responder.sv
// Memory-block target endpoint: takes one request at a time, routes it to RAM,
// boot ROM, I/O or the constant source, and returns data/error on a handshake.
module mblock_responder #(
  parameter int DATA_WIDTH   = 8,
  parameter int RAM_LATENCY  = 1,
  parameter int BROM_LATENCY = 2,
  parameter int IO_TIMEOUT   = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_selector,
  input  logic [15:0]           req_address,
  input  logic                  req_is_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [15:0]           ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  brom_en,
  output logic [15:0]           brom_addr,
  input  logic [DATA_WIDTH-1:0] brom_rdata,
  output logic                  io_valid,
  output logic                  io_we,
  output logic [15:0]           io_addr,
  output logic [DATA_WIDTH-1:0] io_wdata,
  input  logic                  io_ready,
  input  logic [DATA_WIDTH-1:0] io_rdata
);

  localparam logic [1:0] SEL_RAM  = 2'd0;
  localparam logic [1:0] SEL_BROM = 2'd1;
  localparam logic [1:0] SEL_IO   = 2'd2;

  localparam int MAX_RB  = (RAM_LATENCY > BROM_LATENCY) ? RAM_LATENCY : BROM_LATENCY;
  localparam int CNT_MAX = (MAX_RB > IO_TIMEOUT) ? MAX_RB : IO_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RAM_LAST  = CNT_W'(RAM_LATENCY - 1);
  localparam logic [CNT_W-1:0] BROM_LAST = CNT_W'(BROM_LATENCY - 1);
  localparam logic [CNT_W-1:0] IO_LAST   = CNT_W'(IO_TIMEOUT - 1);
  localparam int CONST_W = (DATA_WIDTH < 16) ? DATA_WIDTH : 16;

  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, IO, RESP} state_t;

  state_t                state_reg, state_next;
  logic [1:0]            sel_reg;
  logic [15:0]           addr_reg;
  logic                  we_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic                  error_reg, error_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  accept;

  assign accept = req_valid && (state_reg == IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      error_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      rdata_reg <= rdata_next;
      error_reg <= error_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        sel_reg   <= req_selector;
        addr_reg  <= req_address;
        we_reg    <= req_is_write;
        wdata_reg <= req_wdata;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    rdata_next = rdata_reg;
    error_next = error_reg;
    cnt_next   = cnt_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ram_en     = 1'b0;
    brom_en    = 1'b0;
    io_valid   = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready  = 1'b1;
        rdata_next = '0;
        error_next = 1'b0;
        cnt_next   = '0;
        if (req_valid) state_next = (req_selector == SEL_IO) ? IO : ACCESS;
      end
      ACCESS: begin
        ram_en  = (sel_reg == SEL_RAM);
        brom_en = (sel_reg == SEL_BROM) && !we_reg;
        case (sel_reg)
          SEL_RAM: state_next = WAIT;
          SEL_BROM: begin
            if (we_reg) begin
              error_next = 1'b1;
              state_next = RESP;
            end else begin
              state_next = WAIT;
            end
          end
          default: begin
            // Constant source: the low address bits are the data; writes are rejected.
            error_next = we_reg;
            rdata_next = we_reg ? '0 : DATA_WIDTH'(addr_reg[CONST_W-1:0]);
            state_next = RESP;
          end
        endcase
      end
      WAIT: begin
        if (cnt_reg == ((sel_reg == SEL_RAM) ? RAM_LAST : BROM_LAST)) begin
          state_next = RESP;
          if (sel_reg == SEL_RAM) rdata_next = we_reg ? '0 : ram_rdata;
          else                    rdata_next = brom_rdata;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      IO: begin
        io_valid = 1'b1;
        // A ready on the final allowed edge still wins over the timeout.
        if (io_ready) begin
          rdata_next = we_reg ? '0 : io_rdata;
          state_next = RESP;
        end else if (cnt_reg == IO_LAST) begin
          error_next = 1'b1;
          rdata_next = '0;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ram_we     = ram_en & we_reg;
  assign ram_addr   = ram_en ? addr_reg : '0;
  assign ram_wdata  = ram_en ? wdata_reg : '0;
  assign brom_addr  = brom_en ? addr_reg : '0;
  assign io_we      = io_valid & we_reg;
  assign io_addr    = io_valid ? addr_reg : '0;
  assign io_wdata   = io_valid ? wdata_reg : '0;
  assign resp_rdata = resp_valid ? rdata_reg : '0;
  assign resp_error = resp_valid & error_reg;

endmodule

// File: tb/tb_mblock_responder.sv
// Bench for mblock_responder: transaction-level timing model checked every cycle,
// plus literal expectations on each completed transaction.
module tb_mblock_responder;

  localparam int DW = 8;
  localparam int RL = 1;
  localparam int BL = 2;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready;
  logic [1:0]    req_selector;
  logic [15:0]   req_address;
  logic          req_is_write;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_error;
  logic          ram_en, ram_we;
  logic [15:0]   ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          brom_en;
  logic [15:0]   brom_addr;
  logic [DW-1:0] brom_rdata;
  logic          io_valid, io_we;
  logic [15:0]   io_addr;
  logic [DW-1:0] io_wdata;
  logic          io_ready;
  logic [DW-1:0] io_rdata;

  always #5 clk = ~clk;

  mblock_responder #(
    .DATA_WIDTH(DW), .RAM_LATENCY(RL), .BROM_LATENCY(BL), .IO_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_selector(req_selector),
    .req_address(req_address), .req_is_write(req_is_write), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_error(resp_error),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .brom_en(brom_en), .brom_addr(brom_addr), .brom_rdata(brom_rdata),
    .io_valid(io_valid), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ready(io_ready), .io_rdata(io_rdata)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] brom_fn(input logic [15:0] a);
    return {a[3:0], ~a[3:0]};
  endfunction

  // Backing stores with the configured read latency; off-strobe captures are poisoned.
  logic [7:0] ram_store [256];
  logic [7:0] ram_pipe  [RL];
  logic [7:0] brom_pipe [BL];
  always @(posedge clk) begin
    if (ram_en && ram_we) ram_store[ram_addr[7:0]] <= ram_wdata;
    ram_pipe[0]  <= ram_en ? ram_store[ram_addr[7:0]] : 8'hEE;
    for (int i = 1; i < RL; i++) ram_pipe[i] <= ram_pipe[i-1];
    brom_pipe[0] <= brom_en ? brom_fn(brom_addr) : 8'hEE;
    for (int i = 1; i < BL; i++) brom_pipe[i] <= brom_pipe[i-1];
  end
  assign ram_rdata  = ram_pipe[RL-1];
  assign brom_rdata = brom_pipe[BL-1];

  // I/O target: raises io_ready in the io_delay-th cycle of io_valid (0 = never).
  int         io_delay = 0;
  logic [7:0] io_val   = 8'h00;
  int         io_cnt   = 0;
  initial begin
    io_ready = 1'b0;
    io_rdata = 8'hEE;
  end
  always @(posedge clk) begin
    #1;
    if (io_valid) begin
      io_cnt++;
      io_ready = (io_delay != 0) && (io_cnt == io_delay);
    end else begin
      io_cnt   = 0;
      io_ready = 1'b0;
    end
    io_rdata = io_ready ? io_val : 8'hEE;
  end

  // Transaction-level model: on accept, derive the strobe window and response cycle.
  logic [7:0] exp_mem [logic [15:0]];
  int         cyc = 0;
  bit         m_busy = 0;
  int         m_t, m_resp_t, m_ion;
  logic [1:0] m_sel;
  logic       m_we, m_err;
  logic [15:0] m_addr;
  logic [7:0] m_wd, m_rdata;
  bit         e_ram, e_brom, e_io, e_rv;
  int         obs_acc, obs_first, obs_lat, obs_en, obs_io;
  logic [7:0] obs_rdata;
  logic       obs_err;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_busy = 0;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_brom_en", brom_en, 0);
      chk("rst_io_valid", io_valid, 0);
      chk("rst_resp_valid", resp_valid, 0);
    end else begin
      e_ram  = m_busy && m_sel == 2'd0 && cyc == m_t + 1;
      e_brom = m_busy && m_sel == 2'd1 && !m_we && cyc == m_t + 1;
      e_io   = m_busy && m_sel == 2'd2 && cyc > m_t && cyc <= m_t + m_ion;
      e_rv   = m_busy && cyc >= m_resp_t;
      chk("req_ready", req_ready, !m_busy);
      chk("ram_en", ram_en, e_ram);
      chk("brom_en", brom_en, e_brom);
      chk("io_valid", io_valid, e_io);
      chk("resp_valid", resp_valid, e_rv);
      if (e_ram) begin
        chk("ram_we", ram_we, m_we);
        chk("ram_addr", ram_addr, m_addr);
        if (m_we) chk("ram_wdata", ram_wdata, m_wd);
      end
      if (e_brom) chk("brom_addr", brom_addr, m_addr);
      if (e_io) begin
        chk("io_we", io_we, m_we);
        chk("io_addr", io_addr, m_addr);
        if (m_we) chk("io_wdata", io_wdata, m_wd);
      end
      if (e_rv) begin
        chk("resp_rdata", resp_rdata, m_rdata);
        chk("resp_error", resp_error, m_err);
      end else if (!m_busy) begin
        chk("idle_rdata", resp_rdata, 0);
        chk("idle_error", resp_error, 0);
      end
      if (e_rv && resp_ready) begin
        m_busy = 0;
      end else if (!m_busy && req_valid) begin
        m_busy = 1;
        m_t    = cyc;
        m_sel  = req_selector;
        m_we   = req_is_write;
        m_addr = req_address;
        m_wd   = req_wdata;
        m_ion  = 0;
        case (req_selector)
          2'd0: begin
            m_err = 0;
            m_rdata = m_we ? 8'h00 : (exp_mem.exists(m_addr) ? exp_mem[m_addr] : 8'h00);
            if (m_we) exp_mem[m_addr] = m_wd;
            m_resp_t = cyc + RL + 2;
          end
          2'd1: begin
            m_err    = m_we;
            m_rdata  = m_we ? 8'h00 : brom_fn(m_addr);
            m_resp_t = m_we ? cyc + 2 : cyc + BL + 2;
          end
          2'd2: begin
            m_ion    = (io_delay >= 1 && io_delay <= TO) ? io_delay : TO;
            m_err    = (m_ion != io_delay);
            m_rdata  = (m_err || m_we) ? 8'h00 : io_val;
            m_resp_t = cyc + m_ion + 1;
          end
          default: begin
            m_err    = m_we;
            m_rdata  = m_we ? 8'h00 : m_addr[7:0];
            m_resp_t = cyc + 2;
          end
        endcase
      end
      // What the DUT actually did, for the per-transaction literal checks.
      if (ram_en || brom_en) obs_en++;
      if (io_valid) obs_io++;
      if (resp_valid && obs_first < 0) obs_first = cyc;
      if (resp_valid && resp_ready) begin
        obs_rdata = resp_rdata;
        obs_err   = resp_error;
        obs_lat   = obs_first - obs_acc - 1;
      end
      if (req_valid && req_ready) begin
        obs_acc = cyc; obs_first = -1; obs_en = 0; obs_io = 0;
      end
    end
    cyc++;
  end

  // Issue one request at posedge+2 and return at posedge+2 once back in idle.
  task automatic do_req(input logic [1:0] sel, input logic [15:0] addr,
                        input logic we, input logic [7:0] wd);
    bit got = 0;
    req_selector = sel; req_address = addr; req_is_write = we; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (resp_valid && resp_ready) got = 1;
      @(posedge clk); #2;
    end
    if (!got) chk("resp_timeout", 0, 1);
  endtask

  task automatic expect_txn(input string nm, input logic [7:0] rd, input logic er, input int lat);
    $display("txn %s: rdata=0x%02h err=%0d lat=%0d strobes=%0d io_cycles=%0d",
             nm, obs_rdata, obs_err, obs_lat, obs_en, obs_io);
    chk({nm, "_rdata"}, obs_rdata, rd);
    chk({nm, "_error"}, obs_err, er);
    chk({nm, "_latency"}, obs_lat, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_selector = 2'd0; req_address = 16'h0;
    req_is_write = 1'b0; req_wdata = 8'h00; resp_ready = 1'b1;
    obs_first = -1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_io_valid", io_valid, 0);
    reset_n = 1'b1;
    @(posedge clk); #2;

    do_req(2'd0, 16'h0010, 1'b1, 8'hA5);
    expect_txn("ram_wr", 8'h00, 1'b0, 2);
    chk("ram_wr_en_cycles", obs_en, 1);
    do_req(2'd0, 16'h0010, 1'b0, 8'h00);
    expect_txn("ram_rd", 8'hA5, 1'b0, 2);
    chk("ram_rd_en_cycles", obs_en, 1);

    do_req(2'd1, 16'h0003, 1'b0, 8'h00);
    expect_txn("brom_rd", 8'h3C, 1'b0, 3);
    do_req(2'd1, 16'h0003, 1'b1, 8'h77);
    expect_txn("brom_wr", 8'h00, 1'b1, 1);
    chk("brom_wr_en_cycles", obs_en, 0);

    do_req(2'd3, 16'h12F7, 1'b0, 8'h00);
    expect_txn("const_rd", 8'hF7, 1'b0, 1);
    do_req(2'd3, 16'h12F7, 1'b1, 8'h11);
    expect_txn("const_wr", 8'h00, 1'b1, 1);

    io_delay = 4; io_val = 8'h5E;
    do_req(2'd2, 16'h0040, 1'b0, 8'h00);
    expect_txn("io_rd", 8'h5E, 1'b0, 4);
    chk("io_rd_valid_cycles", obs_io, 4);
    io_delay = 0;
    do_req(2'd2, 16'h0041, 1'b0, 8'h00);
    expect_txn("io_timeout", 8'h00, 1'b1, 15);
    chk("io_timeout_valid_cycles", obs_io, 15);
    io_delay = 15; io_val = 8'h99;
    do_req(2'd2, 16'h0042, 1'b1, 8'h33);
    expect_txn("io_wr_last", 8'h00, 1'b0, 15);
    chk("io_wr_last_valid_cycles", obs_io, 15);

    // Backpressure with a stray request while the response is held.
    resp_ready = 1'b0;
    req_selector = 2'd3; req_address = 16'h0042; req_is_write = 1'b0; req_valid = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !resp_valid; i++) begin
      @(posedge clk); #2;
    end
    chk("bp_resp_seen", resp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        req_selector = 2'd3; req_address = 16'h0099; req_valid = 1'b1;
      end
      if (i == 2) req_valid = 1'b0;
      chk("bp_req_ready", req_ready, 0);
      @(posedge clk); #2;
      chk("bp_hold_valid", resp_valid, 1);
      chk("bp_hold_rdata", resp_rdata, 8'h42);
      chk("bp_hold_error", resp_error, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp_after_req_ready", req_ready, 1);
    repeat (3) begin
      @(posedge clk); #2;
      chk("bp_no_second_resp", resp_valid, 0);
    end
    expect_txn("backpressure", 8'h42, 1'b0, 1);

    // Reset during an I/O wait.
    io_delay = 0;
    req_selector = 2'd2; req_address = 16'h0050; req_is_write = 1'b0; req_valid = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_io_before", io_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_io_drop", io_valid, 0);
    chk("rst_io_no_resp", resp_valid, 0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    chk("rst_io_req_ready", req_ready, 1);
    @(posedge clk); #2;
    do_req(2'd3, 16'h0077, 1'b0, 8'h00);
    expect_txn("post_io_rst_const", 8'h77, 1'b0, 1);

    // Reset during the RAM latency wait.
    req_selector = 2'd0; req_address = 16'h0010; req_is_write = 1'b0; req_valid = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    chk("rst_ram_access_en", ram_en, 1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("rst_ram_en_low", ram_en, 0);
    chk("rst_ram_no_resp", resp_valid, 0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk); #2;
    chk("rst_ram_idle_resp", resp_valid, 0);
    chk("rst_ram_req_ready", req_ready, 1);
    do_req(2'd3, 16'hAB5C, 1'b0, 8'h00);
    expect_txn("post_ram_rst_const", 8'h5C, 1'b0, 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mblock_responder.md
Name: mblock_responder

Overview:
- Target-side endpoint of the memory-block interface: accepts one address/selector/write request per transaction and routes it to RAM, boot ROM, I/O or the constant source.
- Returns read data or a write acknowledgement with a valid/ready response handshake.
- Sits between the per-stage address mux and the backing stores.
- Single outstanding transaction; requests are never queued.

Parameters:
- DATA_WIDTH, 8, width of read/write data.
- RAM_LATENCY, 1, cycles from the ram_en pulse to valid ram_rdata; must be >= 1.
- BROM_LATENCY, 2, cycles from the brom_en pulse to valid brom_rdata; must be >= 1.
- IO_TIMEOUT, 15, maximum cycles io_valid is held waiting for io_ready; must be >= 1.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder idle, can accept
- req_selector  in  2  target select: 0 RAM, 1 BROM, 2 IO, 3 CONST
- req_address  in  16  target address
- req_is_write  in  1  1 = write, 0 = read
- req_wdata  in  DATA_WIDTH  write data
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts response
- resp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- resp_error  out  1  access rejected or timed out
- ram_en, ram_we  out  1 each  RAM access strobe / write enable
- ram_addr  out  16  RAM address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data
- brom_en  out  1  BROM read strobe
- brom_addr  out  16  BROM address
- brom_rdata  in  DATA_WIDTH  BROM read data
- io_valid, io_we  out  1 each  I/O request / write enable
- io_addr  out  16  I/O address
- io_wdata  out  DATA_WIDTH  I/O write data
- io_ready  in  1  I/O completes the access this cycle
- io_rdata  in  DATA_WIDTH  I/O read data, valid when io_ready = 1

Behaviour:

Reset and handshake
- Reset (async, reset_n low): state IDLE; req_ready = 1 (req_ready = state==IDLE). All other outputs 0; counters 0.
- Accept edge E0: req_valid & req_ready. Selector, address, is_write and wdata are registered; req_ready drops after E0.

States and transitions
- States: IDLE, ACCESS, WAIT, IO, RESP.
- RAM: ACCESS holds ram_en = 1 for exactly one cycle, with ram_we = is_write and ram_addr/ram_wdata from registers. WAIT counts RAM_LATENCY cycles, then ram_rdata is sampled (reads) or 0 is used (writes). resp_valid rises RAM_LATENCY+1 cycles after E0.
- BROM read: same sequence as RAM using BROM_LATENCY; resp_valid rises BROM_LATENCY+1 cycles after E0.
- BROM write or CONST write: no target strobe. RESP is entered 1 cycle after E0 with resp_error = 1 and resp_rdata = 0.
- CONST read: resp_rdata = address[DATA_WIDTH-1:0] zero-extended, resp_error = 0, resp_valid 1 cycle after E0.
- IO: io_valid/io_we/io_addr/io_wdata are asserted from the cycle after E0 and held stable.
  - On the first edge with io_ready = 1: capture io_rdata (writes return 0), drop io_valid, go to RESP.
  - If io_ready is not seen within IO_TIMEOUT edges with io_valid high: drop io_valid, resp_error = 1, resp_rdata = 0.
  - io_ready on the same edge as the timeout counts as success.
  - io_ready while io_valid = 0 is ignored.
- RESP: resp_valid held high, with resp_rdata/resp_error stable, until the edge with resp_ready = 1. Then go to IDLE; req_ready = 1 in the next cycle.
  - resp_ready already high when resp_valid rises gives a 1-cycle handshake.
  - Minimum spacing between accepts is 3 cycles (CONST).

Other rules
- resp_error and resp_rdata return to 0 in IDLE.
- Reset asserted mid-transaction: immediately aborts. Strobes drop asynchronously, no response is issued, pending I/O is abandoned.
- Requests presented while req_ready = 0 are ignored and are not captured.

Test Plan:
- RAM write then read, RAM_LATENCY = 1: write addr 0x0010 data 0xA5, then read 0x0010 with a model RAM. Read gives resp_rdata 0xA5 and resp_error 0; ram_en is high exactly 1 cycle per access; resp_valid rises 2 cycles after accept.
- BROM read, BROM_LATENCY = 2, addr 0x0003, model returns 0x3C -> resp 0x3C, 3 cycles after accept. BROM write -> resp_error 1, rdata 0, brom_en never asserted.
- CONST read addr 0x12F7 -> resp_rdata 0xF7, error 0, resp_valid 1 cycle after accept. CONST write -> error 1.
- IO read with io_ready after 4 cycles, io_rdata 0x5E -> resp 0x5E, error 0, io_valid high exactly 4 cycles. io_ready never asserted, IO_TIMEOUT = 15 -> io_valid drops after 15 cycles, resp_error 1, rdata 0.
- Backpressure: hold resp_ready low 5 cycles -> resp_valid, rdata and error stay stable; req_ready stays 0; a second req_valid pulse in this window is not captured.
- Assert reset_n low mid-IO wait and mid-RAM WAIT -> io_valid/ram_en go 0 immediately, no resp_valid; after release req_ready = 1 and a new CONST read completes normally.
